// File: rtl/decode_stage.sv
// Registered RV32I (+optional M) decode stage: decodes InstrD into the execute control bundle
// and sign-extended immediate, held in the D->E pipeline register with valid/ready, hold and flush.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter bit EN_MEXT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           InstrD,
  input  logic [XLEN-1:0]       PCD,
  input  logic                  ValidD,
  output logic                  ReadyD,
  output logic                  ValidE,
  input  logic                  ReadyE,
  input  logic                  FlushE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [1:0]            ALUSrcAE,
  output logic                  ALUSrcBE,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic [2:0]            Funct3E,
  output logic [XLEN-1:0]       PCE,
  output logic                  MulDivE,
  output logic                  IllegalE
);

  if (ALU_CTRL_W < 4) begin : g_bad_alu_width
    $error("decode_stage: ALU_CTRL_W must be >= 4");
  end

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  localparam logic [1:0] SRCA_RS1 = 2'b00, SRCA_PC = 2'b01, SRCA_ZERO = 2'b10;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  typedef struct packed {
    logic       regw;
    logic [1:0] res_src;
    logic       memw;
    logic       jump;
    logic       branch;
    logic [3:0] alu;
    logic [1:0] src_a;
    logic       src_b;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  // funct3 selects the base operation; alt picks SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  ctrl_t           ctrl_d;
  imm_t            imm_sel;
  logic            legal;
  logic [31:0]     imm_raw;
  logic [XLEN-1:0] imm_d;

  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ctrl_d  = '0;
    imm_sel = IMM_NONE;
    legal   = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_d.regw = 1'b1;
        if (funct7 == 7'b0000001) begin
          legal         = EN_MEXT;
          ctrl_d.muldiv = 1'b1;
        end else begin
          legal      = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
          ctrl_d.alu = alu_of(funct3, funct7[5]);
        end
      end
      OP_I: begin
        ctrl_d.regw  = 1'b1;
        ctrl_d.src_b = 1'b1;
        imm_sel      = IMM_I;
        ctrl_d.alu   = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ctrl_d.regw    = 1'b1;
        ctrl_d.res_src = RES_MEM;
        ctrl_d.src_b   = 1'b1;
        imm_sel        = IMM_I;
        legal          = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        ctrl_d.memw  = 1'b1;
        ctrl_d.src_b = 1'b1;
        imm_sel      = IMM_S;
        legal        = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu    = ALU_SUB;
        imm_sel       = IMM_B;
        legal         = !(funct3 inside {3'b010, 3'b011});
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_d.regw  = 1'b1;
        ctrl_d.src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_PC;
        ctrl_d.src_b = 1'b1;
        imm_sel      = IMM_U;
        legal        = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl_d.regw    = 1'b1;
        ctrl_d.res_src = RES_PC4;
        ctrl_d.jump    = 1'b1;
        ctrl_d.src_a   = (opcode == OP_JAL) ? SRCA_PC : SRCA_RS1;
        ctrl_d.src_b   = 1'b1;
        imm_sel        = (opcode == OP_JAL) ? IMM_J : IMM_I;
        legal          = (opcode == OP_JAL) || (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
      imm_sel        = IMM_NONE;
    end
    if (rd == 5'd0) ctrl_d.regw = 1'b0;
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm_raw = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_raw = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_raw = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_U:   imm_raw = {InstrD[31:12], 12'b0};
      IMM_J:   imm_raw = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_raw = '0;
    endcase
  end

  assign imm_d  = XLEN'($signed(imm_raw));
  assign ReadyD = FlushE | ~ValidE | ReadyE;

  ctrl_t           e_ctrl;
  logic [XLEN-1:0] e_imm, e_pc;
  logic [4:0]      e_rs1, e_rs2, e_rd;
  logic [2:0]      e_f3;
  logic            e_valid;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid <= 1'b0;
      e_ctrl  <= '0;
      e_imm   <= '0;
      e_pc    <= '0;
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_rd    <= '0;
      e_f3    <= '0;
    end else if (FlushE || (ReadyE && !ValidD)) begin
      // Flush or drain: the bundle stops being live, so every side-effecting enable drops.
      e_valid        <= 1'b0;
      e_ctrl.regw    <= 1'b0;
      e_ctrl.memw    <= 1'b0;
      e_ctrl.jump    <= 1'b0;
      e_ctrl.branch  <= 1'b0;
      e_ctrl.muldiv  <= 1'b0;
      e_ctrl.illegal <= 1'b0;
    end else if (ValidD && ReadyD) begin
      // PC is kept even for illegal instructions so a trap handler can report it.
      e_valid <= 1'b1;
      e_ctrl  <= ctrl_d;
      e_imm   <= imm_d;
      e_pc    <= PCD;
      e_rs1   <= InstrD[19:15];
      e_rs2   <= InstrD[24:20];
      e_rd    <= rd;
      e_f3    <= funct3;
    end
  end

  assign ValidE      = e_valid;
  assign RegWriteE   = e_ctrl.regw;
  assign ResultSrcE  = e_ctrl.res_src;
  assign MemWriteE   = e_ctrl.memw;
  assign JumpE       = e_ctrl.jump;
  assign BranchE     = e_ctrl.branch;
  assign ALUControlE = ALU_CTRL_W'(e_ctrl.alu);
  assign ALUSrcAE    = e_ctrl.src_a;
  assign ALUSrcBE    = e_ctrl.src_b;
  assign ImmExtE     = e_imm;
  assign Rs1E        = e_rs1;
  assign Rs2E        = e_rs2;
  assign RdE         = e_rd;
  assign Funct3E     = e_f3;
  assign PCE         = e_pc;
  assign MulDivE     = e_ctrl.muldiv;
  assign IllegalE    = e_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations (RV32, RV32M, RV64) driven in lockstep and
// compared every cycle against a decode model, plus hand-computed literal checks.
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic        readyd;
    logic        regw;
    logic [1:0]  ressrc;
    logic        memw;
    logic        jmp;
    logic        br;
    logic [3:0]  alu;
    logic [1:0]  srca;
    logic        srcb;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic        muldiv;
    logic        illegal;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] InstrD;
  logic [63:0] pc64;
  logic        ValidD, ReadyE, FlushE;
  logic        cmp_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  obs_t        obs [3];
  obs_t        exp_b [3];
  logic        exp_v [3];
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  // cfg0: RV32, cfg1: RV32 with M, cfg2: RV64
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int XL = (g == 2) ? 64 : 32;
    localparam bit MX = (g == 1);
    logic          ready_d, valid_e, regw, memw, jump, branch, srcb, muldiv, illegal;
    logic [1:0]    ressrc, srca;
    logic [3:0]    alu;
    logic [XL-1:0] imm, pce;
    logic [4:0]    rs1, rs2, rd;
    logic [2:0]    f3;

    decode_stage #(.XLEN(XL), .ALU_CTRL_W(4), .EN_MEXT(MX)) u_dut (
      .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .PCD(pc64[XL-1:0]), .ValidD(ValidD),
      .ReadyD(ready_d), .ValidE(valid_e), .ReadyE(ReadyE), .FlushE(FlushE),
      .RegWriteE(regw), .ResultSrcE(ressrc), .MemWriteE(memw), .JumpE(jump), .BranchE(branch),
      .ALUControlE(alu), .ALUSrcAE(srca), .ALUSrcBE(srcb), .ImmExtE(imm),
      .Rs1E(rs1), .Rs2E(rs2), .RdE(rd), .Funct3E(f3), .PCE(pce),
      .MulDivE(muldiv), .IllegalE(illegal)
    );

    assign obs[g] = '{valid: valid_e, readyd: ready_d, regw: regw, ressrc: ressrc, memw: memw,
                      jmp: jump, br: branch, alu: alu, srca: srca, srcb: srcb, imm: 64'(imm),
                      rs1: rs1, rs2: rs2, rd: rd, f3: f3, pc: 64'(pce), muldiv: muldiv,
                      illegal: illegal};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected E-side bundle for one instruction, straight from the ISA tables.
  function automatic obs_t model_decode(input logic [31:0] ins, input logic [63:0] pc,
                                        input bit x64, input bit mext);
    obs_t               b;
    logic [6:0]         op, f7;
    logic [2:0]         f3;
    logic signed [63:0] imm;
    logic [3:0]         alu_of [8];
    bit                 ok;
    alu_of = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    b = '0;
    imm = 0;
    ok = 1;
    case (op)
      7'b0110011: begin
        b.regw = 1;
        if (f7 == 7'b0000001) begin
          ok = mext;
          b.muldiv = 1;
        end else begin
          ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
          b.alu = alu_of[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
        end
      end
      7'b0010011: begin
        b.regw = 1; b.srcb = 1;
        imm = $signed(ins[31:20]);
        b.alu = alu_of[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20);
          if (f7 == 7'h20) b.alu = b.alu + 4'd1;
        end
      end
      7'b0000011: begin
        b.regw = 1; b.ressrc = 2'b01; b.srcb = 1;
        imm = $signed(ins[31:20]);
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'b0100011: begin
        b.memw = 1; b.srcb = 1;
        imm = $signed({ins[31:25], ins[11:7]});
        ok = f3 inside {3'd0, 3'd1, 3'd2};
      end
      7'b1100011: begin
        b.br = 1; b.alu = 4'd1;
        imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        ok = !(f3 inside {3'd2, 3'd3});
      end
      7'b0110111, 7'b0010111: begin
        b.regw = 1; b.srcb = 1;
        b.srca = (op == 7'b0110111) ? 2'b10 : 2'b01;
        imm = $signed({ins[31:12], 12'b0});
      end
      7'b1101111: begin
        b.regw = 1; b.ressrc = 2'b10; b.jmp = 1; b.srca = 2'b01; b.srcb = 1;
        imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      end
      7'b1100111: begin
        b.regw = 1; b.ressrc = 2'b10; b.jmp = 1; b.srcb = 1;
        imm = $signed(ins[31:20]);
        ok = (f3 == 0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      b = '0;
      b.illegal = 1;
    end else begin
      b.imm = imm;
    end
    b.valid = 1;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd = ins[11:7];
    b.f3 = f3;
    b.pc = pc;
    if (b.rd == 0) b.regw = 0;
    if (!x64) begin
      b.imm[63:32] = '0;
      b.pc[63:32] = '0;
    end
    return b;
  endfunction

  // Pipeline-register model plus an in-order scoreboard of accepted PCs (cfg0).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 3; g++) begin
        exp_v[g] <= 1'b0;
        exp_b[g] <= '0;
      end
      sb.delete();
    end else begin
      if (obs[0].valid && ReadyE && !FlushE) begin
        if (sb.size() == 0) check("sb.underflow", 1, 0);
        else check("sb.PCE_order", obs[0].pc, sb.pop_front());
      end
      if (FlushE) sb.delete();
      else if (ValidD && (!exp_v[0] || ReadyE)) sb.push_back({32'b0, pc64[31:0]});
      for (int g = 0; g < 3; g++) begin
        if (FlushE || (ReadyE && !ValidD)) begin
          exp_v[g] <= 1'b0;
          exp_b[g].regw <= 1'b0;
          exp_b[g].memw <= 1'b0;
          exp_b[g].jmp <= 1'b0;
          exp_b[g].br <= 1'b0;
        end else if (ValidD && (!exp_v[g] || ReadyE)) begin
          exp_v[g] <= 1'b1;
          exp_b[g] <= model_decode(InstrD, pc64, g == 2, g == 1);
        end
      end
    end
  end

  task automatic compare_cfg(input int g);
    string p;
    p = $sformatf("cfg%0d.", g);
    check({p, "ValidE"}, obs[g].valid, exp_v[g]);
    check({p, "ReadyD"}, obs[g].readyd, FlushE || !exp_v[g] || ReadyE);
    check({p, "RegWriteE"}, obs[g].regw, exp_b[g].regw);
    check({p, "MemWriteE"}, obs[g].memw, exp_b[g].memw);
    check({p, "JumpE"}, obs[g].jmp, exp_b[g].jmp);
    check({p, "BranchE"}, obs[g].br, exp_b[g].br);
    if (exp_v[g]) begin
      check({p, "ResultSrcE"}, obs[g].ressrc, exp_b[g].ressrc);
      check({p, "ALUControlE"}, obs[g].alu, exp_b[g].alu);
      check({p, "ALUSrcAE"}, obs[g].srca, exp_b[g].srca);
      check({p, "ALUSrcBE"}, obs[g].srcb, exp_b[g].srcb);
      check({p, "ImmExtE"}, obs[g].imm, exp_b[g].imm);
      check({p, "Rs1E"}, obs[g].rs1, exp_b[g].rs1);
      check({p, "Rs2E"}, obs[g].rs2, exp_b[g].rs2);
      check({p, "RdE"}, obs[g].rd, exp_b[g].rd);
      check({p, "Funct3E"}, obs[g].f3, exp_b[g].f3);
      check({p, "MulDivE"}, obs[g].muldiv, exp_b[g].muldiv);
      check({p, "IllegalE"}, obs[g].illegal, exp_b[g].illegal);
      if (!exp_b[g].illegal) check({p, "PCE"}, obs[g].pc, exp_b[g].pc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int g = 0; g < 3; g++) compare_cfg(g);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic re, input logic fl);
    ValidD = v; InstrD = ins; pc64 = pc; ReadyE = re; FlushE = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction in, then idle with ReadyE high; outputs are checked right after the load edge.
  task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
    drive(1, ins, pc, 1, 0);
    tick;
    drive(0, 32'h0, 64'h0, 1, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] prog [4];
    logic        re_pat [4];
    logic [31:0] misc [10];
    logic        acc, re;
    int          i, cyc;
    prog   = '{32'h40208333, 32'h4030D213, 32'h00208463, 32'h0040A283};
    re_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    misc   = '{32'hFFFFFFFF, 32'h40209333, 32'h40109093, 32'h0000B283, 32'h0020A463,
               32'h004100E7, 32'h00000013, 32'hFE20AE23, 32'hFE209CE3, 32'h0220D1B3};

    reset_n = 1'b0;
    drive(0, 32'h0, 64'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;

    // 1: async reset while a bundle is being held
    drive(1, 32'hFFF00293, 64'h80, 0, 0);
    tick;
    drive(0, 32'h0, 64'h0, 0, 0);
    check("t1.loaded_ValidE", obs[0].valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t1.ValidE", obs[0].valid, 0);
    check("t1.ReadyD", obs[0].readyd, 1);
    check("t1.RegWriteE", obs[0].regw, 0);
    check("t1.ImmExtE", obs[0].imm, 0);
    check("t1.RdE", obs[0].rd, 0);
    check("t1.PCE", obs[2].pc, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 2: addi x5,x0,-1 then a 3-cycle stall
    drive(1, 32'hFFF00293, 64'h100, 1, 0);
    tick;
    drive(0, 32'h0, 64'h0, 0, 0);
    check("t2.ValidE", obs[0].valid, 1);
    check("t2.RdE", obs[0].rd, 5);
    check("t2.ImmExtE", obs[0].imm, 64'hFFFF_FFFF);
    check("t2.ALUSrcBE", obs[0].srcb, 1);
    check("t2.RegWriteE", obs[0].regw, 1);
    check("t2.ImmExtE64", obs[2].imm, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) begin
      tick;
      check("t2.hold_ValidE", obs[0].valid, 1);
      check("t2.hold_ImmExtE", obs[0].imm, 64'hFFFF_FFFF);
      check("t2.hold_ReadyD", obs[0].readyd, 0);
    end
    drive(0, 32'h0, 64'h0, 1, 0);
    tick;
    check("t2.drain_ValidE", obs[0].valid, 0);
    check("t2.drain_RegWriteE", obs[0].regw, 0);

    // 3: flush kills a held bundle and drops a same-cycle sw
    drive(1, 32'hFFF00293, 64'h180, 0, 0);
    tick;
    drive(1, 32'h0020A423, 64'h200, 0, 1);
    tick;
    drive(0, 32'h0, 64'h0, 1, 0);
    check("t3.flush_ValidE", obs[0].valid, 0);
    check("t3.flush_MemWriteE", obs[0].memw, 0);
    check("t3.flush_RegWriteE", obs[0].regw, 0);
    issue(32'h0020A423, 64'h204);
    check("t3.sw_MemWriteE", obs[0].memw, 1);
    check("t3.sw_ImmExtE", obs[0].imm, 8);
    check("t3.sw_RegWriteE", obs[0].regw, 0);

    // 4: jal / auipc / lui
    issue(32'hFFDFF0EF, 64'h300);
    check("t4.jal_JumpE", obs[0].jmp, 1);
    check("t4.jal_ResultSrcE", obs[0].ressrc, 2'b10);
    check("t4.jal_ALUSrcAE", obs[0].srca, 2'b01);
    check("t4.jal_ImmExtE", obs[0].imm, 64'hFFFF_FFFC);
    issue(32'h12345397, 64'h304);
    check("t4.auipc_ImmExtE", obs[0].imm, 64'h1234_5000);
    check("t4.auipc_ALUSrcAE", obs[0].srca, 2'b01);
    issue(32'h123453B7, 64'h308);
    check("t4.lui_ImmExtE", obs[0].imm, 64'h1234_5000);
    check("t4.lui_ALUSrcAE", obs[0].srca, 2'b10);

    // 5: mul x3,x1,x2 with and without the M extension
    issue(32'h022081B3, 64'h400);
    check("t5.noM_IllegalE", obs[0].illegal, 1);
    check("t5.noM_RegWriteE", obs[0].regw, 0);
    check("t5.noM_ValidE", obs[0].valid, 1);
    check("t5.M_MulDivE", obs[1].muldiv, 1);
    check("t5.M_RegWriteE", obs[1].regw, 1);
    check("t5.M_ALUControlE", obs[1].alu, 0);

    // 6: back-to-back stream with ReadyE 1,0,1,1
    i = 0;
    cyc = 0;
    while (i < 4 && cyc < 20) begin
      re = (cyc < 4) ? re_pat[cyc] : 1'b1;
      drive(1, prog[i], 64'h1000 + 64'(4 * i), re, 0);
      acc = !exp_v[0] || ReadyE;
      tick;
      if (acc) i++;
      cyc++;
    end
    if (i < 4) check("t6.timeout", 0, 1);

    // Misc legality corners, back-to-back
    for (int k = 0; k < 10; k++) begin
      drive(1, misc[k], 64'h2000 + 64'(4 * k), 1, 0);
      tick;
    end

    drive(0, 32'h0, 64'h0, 1, 0);
    repeat (3) tick;
    check("sb.empty_at_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
